// File: rtl/md_unit_pkg.sv
// rtl/md_unit_pkg.sv - MDU opcode encodings, cycle constants and op classification
// MDU_MADD_EN selects whether MADD decodes as a multiply or as NONE.
package md_unit_pkg;

  localparam int MDU_CNT_W       = 4;
  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  typedef enum logic [2:0] {
    MD_NONE  = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MADD  = 3'b101,
    MD_MTHI  = 3'b110,
    MD_MTLO  = 3'b111
  } mdOpT;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_MUL,
    CLS_DIV,
    CLS_MOVE
  } mdClsT;

  // Result captured into the shadow registers at launch; commit=0 keeps HI/LO untouched.
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        commit;
  } mdResT;

  function automatic mdClsT classifyOp(input mdOpT op);
    mdClsT cls;
    case (op)
      MD_MULT, MD_MULTU: cls = CLS_MUL;
      MD_DIV, MD_DIVU:   cls = CLS_DIV;
`ifdef MDU_MADD_EN
      MD_MADD:           cls = CLS_MUL;
`endif
      MD_MTHI, MD_MTLO:  cls = CLS_MOVE;
      default:           cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/md_unit.sv
// rtl/md_unit.sv - execute-stage multiply/divide unit owning HI/LO, fixed multi-cycle latency
// Define MDU_MADD_EN to enable MADD ({HI,LO} += signed A*B); otherwise MADD behaves as NONE.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [MDU_CNT_W-1:0] MULT_CNT = MDU_CNT_W'(MULT_CYCLES);
  localparam logic [MDU_CNT_W-1:0] DIV_CNT  = MDU_CNT_W'(DIV_CYCLES);

  logic [31:0]          hiQ;
  logic [31:0]          loQ;
  logic [31:0]          hiN;
  logic [31:0]          loN;
  logic                 commitN;
  logic [MDU_CNT_W-1:0] cnt;
  logic                 busyQ;

  mdOpT  op;
  mdClsT opCls;
  logic  launch;

  logic signed [63:0]   prodS;
  logic [63:0]          prodU;
  logic [31:0]          divisorU;
  logic signed [31:0]   divisorS;
  logic signed [31:0]   quotS;
  logic signed [31:0]   remS;
  logic [31:0]          quotU;
  logic [31:0]          remU;
  logic                 divOverflow;
`ifdef MDU_MADD_EN
  logic [63:0]          maddSum;
`endif
  mdResT                res;
  logic [MDU_CNT_W-1:0] resCycles;

  assign op     = mdOpT'(MDOp);
  assign opCls  = classifyOp(op);
  assign launch = Start && !busyQ && (opCls == CLS_MUL || opCls == CLS_DIV);

  always_comb begin
    prodS = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prodU = {32'd0, A} * {32'd0, B};
`ifdef MDU_MADD_EN
    maddSum = {hiQ, loQ} + prodS;
`endif
    // Substitute a divisor of 1 on B==0 so the datapath never sees x; the result is discarded.
    divisorU    = (B == 32'd0) ? 32'd1 : B;
    divisorS    = $signed(divisorU);
    divOverflow = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    if (divOverflow) begin
      quotS = $signed(A);
      remS  = '0;
    end else begin
      quotS = $signed(A) / divisorS;
      remS  = $signed(A) % divisorS;
    end
    quotU = A / divisorU;
    remU  = A % divisorU;
  end

  always_comb begin
    res       = '{hi: hiQ, lo: loQ, commit: 1'b0};
    resCycles = '0;
    case (op)
      MD_MULT: begin
        res       = '{hi: prodS[63:32], lo: prodS[31:0], commit: 1'b1};
        resCycles = MULT_CNT;
      end
      MD_MULTU: begin
        res       = '{hi: prodU[63:32], lo: prodU[31:0], commit: 1'b1};
        resCycles = MULT_CNT;
      end
`ifdef MDU_MADD_EN
      MD_MADD: begin
        res       = '{hi: maddSum[63:32], lo: maddSum[31:0], commit: 1'b1};
        resCycles = MULT_CNT;
      end
`endif
      MD_DIV: begin
        res       = '{hi: remS, lo: quotS, commit: (B != 32'd0)};
        resCycles = DIV_CNT;
      end
      MD_DIVU: begin
        res       = '{hi: remU, lo: quotU, commit: (B != 32'd0)};
        resCycles = DIV_CNT;
      end
      default: begin
        res       = '{hi: hiQ, lo: loQ, commit: 1'b0};
        resCycles = '0;
      end
    endcase
  end

  // busyQ mirrors (cnt != 0) as its own flop so Busy leaves the block straight from a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      hiQ     <= '0;
      loQ     <= '0;
      hiN     <= '0;
      loN     <= '0;
      commitN <= 1'b0;
      cnt     <= '0;
      busyQ   <= 1'b0;
    end else if (launch) begin
      hiN     <= res.hi;
      loN     <= res.lo;
      commitN <= res.commit;
      cnt     <= resCycles;
      busyQ   <= 1'b1;
    end else if (busyQ) begin
      cnt <= cnt - 1'b1;
      if (cnt == MDU_CNT_W'(1)) begin
        busyQ <= 1'b0;
        if (commitN) begin
          hiQ <= hiN;
          loQ <= loN;
        end
      end
    end else if (Start) begin
      case (op)
        MD_MTHI: hiQ <= A;
        MD_MTLO: loQ <= A;
        default: ;
      endcase
    end
  end

  // The stall logic must hold md/mt ops in D while Busy; a leaked Start must not disturb the op in flight.
  assert property (@(posedge clk) disable iff (reset)
    (Start && busyQ) |=> ($stable(hiN) && $stable(loN) && $stable(commitN)))
    else $error("md_unit: Start accepted while Busy");

  assign Busy = busyQ;
  assign HI   = hiQ;
  assign LO   = loQ;

endmodule
